// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage.
// Shift-add multiply, restoring divide; fixed DATA_WIDTH+1 cycle latency.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_data1,
    input  logic [DATA_WIDTH-1:0] src_data2,
    input  logic [RD_WIDTH:0]     rd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [RD_WIDTH:0]     rd_out,
    output logic                  busy
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W);
    localparam logic [RD_WIDTH:0] NO_RD = {1'b1, {RD_WIDTH{1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                 accept;
    logic [2:0]           op_q;
    logic [RD_WIDTH:0]    rd_q;
    logic                 sign_a;
    logic                 sign_b;
    logic [W-1:0]         opa;
    logic [W-1:0]         opb;
    logic [W-1:0]         shreg;
    logic [2*W-1:0]       acc;
    logic [CNT_WIDTH-1:0] cnt;

    logic         sgn_rs1;
    logic         sgn_rs2;
    logic         neg_a;
    logic         neg_b;
    logic [W-1:0] abs_a;
    logic [W-1:0] abs_b;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] div_next;

    logic           neg_p;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo_mag;
    logic [W-1:0]   rem_mag;
    logic [W-1:0]   fix;

    assign in_ready = !cpu_rst && !flush &&
                      (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        sgn_rs1 = 1'b0;
        sgn_rs2 = 1'b0;
        unique case (op)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn_rs1 = 1'b1;
                sgn_rs2 = 1'b1;
            end
            OP_MULHSU: sgn_rs1 = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes are W-bit unsigned, so |most-negative| fits exactly.
    assign neg_a = sgn_rs1 & src_data1[W-1];
    assign neg_b = sgn_rs2 & src_data2[W-1];
    assign abs_a = neg_a ? {W{1'b0}} - src_data1 : src_data1;
    assign abs_b = neg_b ? {W{1'b0}} - src_data2 : src_data2;

    assign mul_sum  = {1'b0, acc[2*W-1:W]} +
                      (shreg[0] ? {1'b0, opa} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc[W-1:1]};

    // acc holds {partial remainder, quotient}; shreg feeds dividend bits.
    assign div_shift = {acc[2*W-1:W], shreg[W-1]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_rem   = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
    assign div_next  = {div_rem, acc[W-2:0], ~div_diff[W]};

    assign neg_p   = sign_a ^ sign_b;
    assign prod    = neg_p ? {(2*W){1'b0}} - acc : acc;
    assign quo_mag = acc[W-1:0];
    assign rem_mag = acc[2*W-1:W];

    always_comb begin
        fix = prod[W-1:0];
        unique case (op_q)
            OP_MUL: fix = prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix = prod[2*W-1:W];
            OP_DIV, OP_DIVU: begin
                if (opb == {W{1'b0}})
                    fix = {W{1'b1}};
                else
                    fix = neg_p ? {W{1'b0}} - quo_mag : quo_mag;
            end
            default: fix = sign_a ? {W{1'b0}} - rem_mag : rem_mag;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == LAST)
                    state_nxt = DONE;
            end
            DONE: begin
                if (flush)
                    state_nxt = IDLE;
                else if (out_ready)
                    state_nxt = accept ? CALC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            op_q   <= 3'd0;
            rd_q   <= NO_RD;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            shreg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            rd_out <= NO_RD;
        end else if (flush && state != IDLE) begin
            rd_out <= NO_RD;
            cnt    <= '0;
        end else if (accept) begin
            op_q   <= op;
            rd_q   <= rd_in;
            sign_a <= neg_a;
            sign_b <= neg_b;
            opa    <= abs_a;
            opb    <= abs_b;
            shreg  <= op[2] ? abs_a : abs_b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            // Extra edge after the last iteration applies the sign fix-up.
            if (cnt == LAST) begin
                result <= fix;
                rd_out <= rd_q;
                cnt    <= '0;
            end else begin
                if (op_q[2]) begin
                    acc   <= div_next;
                    shreg <= {shreg[W-2:0], 1'b0};
                end else begin
                    acc   <= mul_next;
                    shreg <= {1'b0, shreg[W-1:1]};
                end
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed RV32M ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W   = 32;
    localparam int RDW = 5;
    localparam int LAT = 33;

    logic           cpu_clk = 1'b0;
    logic           cpu_rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op;
    logic [W-1:0]   src_data1;
    logic [W-1:0]   src_data2;
    logic [RDW:0]   rd_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic [RDW:0]   rd_out;
    logic           busy;

    logic rand_rdy = 1'b0;
    logic rdy_val  = 1'b1;
    logic rnd_bit  = 1'b1;

    assign out_ready = rand_rdy ? rnd_bit : rdy_val;

    muldiv_unit #(.DATA_WIDTH(W), .RD_WIDTH(RDW), .CNT_WIDTH(6)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .src_data1(src_data1),
        .src_data2(src_data2),
        .rd_in    (rd_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .rd_out   (rd_out),
        .busy     (busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    int cyc = 0;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    always @(posedge cpu_clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    typedef struct {
        logic [W-1:0] res;
        logic [RDW:0] rd;
        int           t_acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_ov = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] o,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int sa;
        int sb;
        logic [63:0] p;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin
                p = {32'b0, a} * {32'b0, b};
                return p[31:0];
            end
            3'd1: begin
                p = longint'(sa) * longint'(sb);
                return p[63:32];
            end
            3'd2: begin
                p = longint'(sa) * longint'({32'b0, b});
                return p[63:32];
            end
            3'd3: begin
                p = {32'b0, a} * {32'b0, b};
                return p[63:32];
            end
            3'd4: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return '1;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    always @(negedge cpu_clk) begin
        if (cpu_rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out_valid: result %h rd %0d at cycle %0d",
                             result, rd_out, cyc);
                end else begin
                    if (!prev_ov)
                        chk("latency", 32'(cyc - exp_q[0].t_acc), LAT);
                    chk("result", result, exp_q[0].res);
                    chk("rd_out", 32'(rd_out), 32'(exp_q[0].rd));
                end
            end
            if (flush) begin
                if (exp_q.size() > 0) exp_q.delete(0);
            end else if (out_valid && out_ready && exp_q.size() > 0) begin
                exp_q.delete(0);
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.res   = model(op, src_data1, src_data2);
                e.rd    = rd_in;
                e.t_acc = cyc + 1;
                exp_q.push_back(e);
            end
            prev_ov = out_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [RDW:0] rd);
        op        = o;
        src_data1 = a;
        src_data2 = b;
        rd_in     = rd;
        in_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge cpu_clk);
            if (in_ready) begin
                @(posedge cpu_clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: in_ready low for 200 cycles, op %0d", o);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge cpu_clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
        exp_q.delete();
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [RDW:0] rd);
        issue(o, a, b, rd);
        drain();
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        cpu_rst   = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        src_data1 = '0;
        src_data2 = '0;
        rd_in     = '0;

        repeat (2) @(posedge cpu_clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", result, 0);
        chk("rst_rd_out", 32'(rd_out), 32);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        @(posedge cpu_clk);
        #1;

        run(3'd0, 32'h7, 32'hFFFF_FFFD, 6'd5);
        run(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd1);
        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd2);
        run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 6'd3);
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 6'd4);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 6'd6);
        run(3'd5, 32'd100, 32'd7, 6'd7);
        run(3'd7, 32'd100, 32'd7, 6'd8);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11);
        run(3'd5, 32'd5, 32'd0, 6'd12);
        run(3'd7, 32'd5, 32'd0, 6'd13);
        run(3'd4, 32'hFFFF_FFF9, 32'd0, 6'd14);
        run(3'd6, 32'hFFFF_FFF9, 32'd0, 6'd15);
        run(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 6'd32);

        // Hold the result in DONE, then complete and accept on one edge.
        rdy_val = 1'b0;
        issue(3'd3, $urandom, $urandom, 6'd9);
        for (int i = 0; i < 60; i++) begin
            @(negedge cpu_clk);
            if (out_valid) break;
        end
        chk("hold_reached_done", 32'(out_valid), 1);
        repeat (4) begin
            @(negedge cpu_clk);
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        @(posedge cpu_clk);
        #1;
        rdy_val   = 1'b1;
        op        = 3'd4;
        src_data1 = 32'hFFFF_FF00;
        src_data2 = 32'd7;
        rd_in     = 6'd12;
        in_valid  = 1'b1;
        @(negedge cpu_clk);
        chk("b2b_in_ready", 32'(in_ready), 1);
        @(posedge cpu_clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Flush mid-CALC together with a new request.
        issue(3'd1, $urandom, $urandom, 6'd3);
        repeat (9) @(posedge cpu_clk);
        #1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        op        = 3'd5;
        src_data1 = 32'd50;
        src_data2 = 32'd3;
        rd_in     = 6'd20;
        @(negedge cpu_clk);
        chk("flush_in_ready", 32'(in_ready), 0);
        @(posedge cpu_clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge cpu_clk);
        chk("flush_busy", 32'(busy), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_rd_out", 32'(rd_out), 32);
        repeat (45) @(posedge cpu_clk);
        #1;

        // Asynchronous reset in the middle of CALC.
        issue(3'd4, $urandom, $urandom, 6'd7);
        repeat (10) @(posedge cpu_clk);
        #3;
        cpu_rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_result", result, 0);
        chk("arst_rd_out", 32'(rd_out), 32);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        @(posedge cpu_clk);
        #1;

        rand_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
                  6'($urandom_range(0, 32)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge cpu_clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        rdy_val  = 1'b1;
        drain();
        repeat (3) @(posedge cpu_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
